dcf77_signal_gen: RTL and testbench
===================================

Name: dcf77_signal_gen

Overview:
- Transmitter side of the DCF77 time path. Takes the 44-bit timeAndDate vector, the same format the clock core and the decoder use, and serialises it into a DCF77-style pulse train.
- Output is one pulse per second, 59 pulses per minute plus the minute gap.
- Used as the stimulus source for the receiver/decoder chain on the board and in simulation, in place of a real antenna module.

Parameters:
- CLKS_PER_MS, 10, clk cycles per 1 ms tick (default = 10 kHz clock); legal range 1 to 65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable_In  input  1  1 = transmit frames continuously; 0 = idle.
- timeAndDate_In  input  44  time/date vector; sampled only at frame start.
- dcfSignal_Out  output  1  1 = carrier-reduction pulse active; 0 = full carrier.
- frameStart_Out  output  1  one-cycle strobe in the cycle that second 0 begins (also the latch cycle).
- secondIndex_Out  output  6  current second index 0..59; 0 while idle.

Behaviour:
- Reset (async):
  - State IDLE.
  - dcfSignal_Out=0, frameStart_Out=0, secondIndex_Out=0.
  - Prescaler, ms counter and latched frame all cleared to 0.
- Input vector layout:
  - [3:0] sec lo, [6:4] sec hi.
  - [10:7] min lo, [13:11] min hi.
  - [17:14] hour lo, [19:18] hour hi.
  - [23:20] day lo, [25:24] day hi.
  - [29:26] month lo, [30] month hi.
  - [34:31] year lo, [38:35] year hi.
  - [41:39] weekday (1=Mon..7=Sun), [43:42] timezone.
  - Seconds fields are ignored.
- Frame bit map (fields LSB first):
  - bit 0 M=0; bits 1..15 = 0; bit 16 A1=0.
  - bit 17 = tz[43], bit 18 = tz[42]; bit 19 A2=0; bit 20 S=1.
  - bits 21..24 min lo, 25..27 min hi, 28 P1.
  - bits 29..32 hour lo, 33..34 hour hi, 35 P2.
  - bits 36..39 day lo, 40..41 day hi, 42..44 weekday.
  - bits 45..48 month lo, 49 month hi.
  - bits 50..53 year lo, 54..57 year hi, 58 P3.
  - Second 59: no pulse.
- Parity: P1 = XOR of bits 21..27, P2 = XOR of 29..34, P3 = XOR of 36..57 (even parity). Computed from the latched frame.
- Timing counters:
  - Prescaler counts 0..CLKS_PER_MS-1; wrap produces the ms tick.
  - ms counter (10 bit) counts 0..999 on ticks; wrap advances the second.
  - Second length is exactly 1000*CLKS_PER_MS cycles.
- Pulse rule: for seconds 0..58, dcfSignal_Out=1 while ms < 100 (bit=0) or ms < 200 (bit=1), else 0. Second 59: dcfSignal_Out=0 for the whole second.
- Pulse duration is exactly 100*CLKS_PER_MS or 200*CLKS_PER_MS cycles.
- FSM:
  - IDLE → RUN on the first edge with enable_In=1. On that edge:
    - latch timeAndDate_In;
    - set sec=0, ms=0, prescaler=0;
    - frameStart_Out<=1, dcfSignal_Out<=1.
  - Output is registered, so dcfSignal_Out and frameStart_Out rise on the same edge.
  - RUN, second 59 wraps to 0: same edge relatches timeAndDate_In, strobes frameStart_Out and starts the second-0 pulse.
  - RUN with enable_In=0 sampled: next edge → IDLE; all outputs 0 and counters cleared. This truncates any in-progress pulse and discards the frame.
  - Re-enable always restarts at second 0.
- timeAndDate_In changes mid-frame have no effect until the next frame start.
- No range checking of BCD digits; values are transmitted as given.
- frameStart_Out is never high for more than one consecutive cycle.

Optional Feature:
- Macro DCF_PARITY_INJECT_EN.
- Defined:
  - Adds input port parityErr_In (1 bit), sampled together with timeAndDate_In at frame start.
  - If it is 1, P1, P2 and P3 are all inverted for that whole frame.
- Undefined: port absent; parities are always correct.

Test Plan:
- Reset mid-pulse (assert reset while dcfSignal_Out=1) → all outputs 0 in the same cycle; after release, IDLE until enable_In.
- CLKS_PER_MS=10, vector Tue 2019/07/31 23:59:45, tz=00, enable_In=1 → frameStart_Out pulse. Pulses are then:
  - sec 0: 1000 cycles; sec 20: 2000 cycles;
  - secs 21..27 lengths (bits) 1,0,0,1,1,0,1; P1=0;
  - secs 29..34 = 1,1,0,0,0,1; P2=1; P3=0;
  - sec 59 no pulse; next frameStart exactly 600000 cycles after the first.
- Change timeAndDate_In to 00:00 at second 30 → current frame is unchanged; the following frame carries minute/hour bits all 0 and P1=P2=0.
- Drop enable_In at second 12, ms 50 → dcfSignal_Out=0 and secondIndex_Out=0 one cycle later. Re-enable → new frameStart and second 0 restarts.
- tz=2'b10 → sec 17 is 200 ms, sec 18 is 100 ms. tz=2'b01 → the reverse.
- With DCF_PARITY_INJECT_EN and parityErr_In=1 at frame start → for the vector above, P1=1, P2=0, P3=1; other bits unchanged.

Source files
------------

// File: rtl/dcf77_signal_gen_if.sv
// Port bundle for dcf77_signal_gen: frame control/data in, pulse train and status out.
// parityErr_In exists only when DCF_PARITY_INJECT_EN is defined.
interface dcf77_signal_gen_if;
  logic        enable_In;
  logic [43:0] timeAndDate_In;
`ifdef DCF_PARITY_INJECT_EN
  logic        parityErr_In;
`endif
  logic        dcfSignal_Out;
  logic        frameStart_Out;
  logic [5:0]  secondIndex_Out;

`ifdef DCF_PARITY_INJECT_EN
  modport master (
    output enable_In, timeAndDate_In, parityErr_In,
    input  dcfSignal_Out, frameStart_Out, secondIndex_Out
  );
  modport slave (
    input  enable_In, timeAndDate_In, parityErr_In,
    output dcfSignal_Out, frameStart_Out, secondIndex_Out
  );
`else
  modport master (
    output enable_In, timeAndDate_In,
    input  dcfSignal_Out, frameStart_Out, secondIndex_Out
  );
  modport slave (
    input  enable_In, timeAndDate_In,
    output dcfSignal_Out, frameStart_Out, secondIndex_Out
  );
`endif
endinterface

// File: rtl/dcf77_signal_gen.sv
// DCF77-style pulse-train generator: serialises a latched time/date vector, one bit per second.
// Optional macro DCF_PARITY_INJECT_EN adds parityErr_In, which inverts P1/P2/P3 for a frame.
module dcf77_signal_gen #(
  parameter int unsigned CLKS_PER_MS = 10
) (
  input logic               clk,
  input logic               reset,
  dcf77_signal_gen_if.slave bus
);

  localparam logic [15:0] PrescMax = 16'(CLKS_PER_MS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q;
  logic [15:0] presc_q, presc_d;
  logic [9:0]  ms_q, ms_d;
  logic [5:0]  sec_q, sec_d;
  logic [43:7] tad_q;
  logic        perr_q;
  logic        dcf_q, dcf_d;
  logic        fs_q;
  logic        ms_tick, sec_tick, frame_wrap;
  logic [63:0] frame_bits;
  logic        unused_sec_in;

  // Seconds fields of the input vector are never transmitted.
  assign unused_sec_in = ^bus.timeAndDate_In[6:0];

  always_comb begin
    frame_bits        = '0;
    frame_bits[17]    = tad_q[43];
    frame_bits[18]    = tad_q[42];
    frame_bits[20]    = 1'b1;
    frame_bits[27:21] = tad_q[13:7];
    frame_bits[28]    = ^tad_q[13:7] ^ perr_q;
    frame_bits[34:29] = tad_q[19:14];
    frame_bits[35]    = ^tad_q[19:14] ^ perr_q;
    frame_bits[41:36] = tad_q[25:20];
    frame_bits[44:42] = tad_q[41:39];
    frame_bits[49:45] = tad_q[30:26];
    frame_bits[57:50] = tad_q[38:31];
    frame_bits[58]    = ^frame_bits[57:36] ^ perr_q;
  end

  always_comb begin
    ms_tick    = (presc_q == PrescMax);
    sec_tick   = ms_tick && (ms_q == 10'd999);
    frame_wrap = sec_tick && (sec_q == 6'd59);
    presc_d    = ms_tick ? 16'd0 : presc_q + 16'd1;
    ms_d       = sec_tick ? 10'd0 : (ms_tick ? ms_q + 10'd1 : ms_q);
    sec_d      = frame_wrap ? 6'd0 : (sec_tick ? sec_q + 6'd1 : sec_q);
    // Pulse level for the position the counters move to on this edge; second 59 stays low.
    dcf_d      = (sec_d != 6'd59) && (ms_d < (frame_bits[sec_d] ? 10'd200 : 10'd100));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      ms_q    <= '0;
      sec_q   <= '0;
      tad_q   <= '0;
      perr_q  <= 1'b0;
      dcf_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.enable_In) begin
            state_q <= StRun;
            tad_q   <= bus.timeAndDate_In[43:7];
`ifdef DCF_PARITY_INJECT_EN
            perr_q  <= bus.parityErr_In;
`else
            perr_q  <= 1'b0;
`endif
            presc_q <= '0;
            ms_q    <= '0;
            sec_q   <= '0;
            fs_q    <= 1'b1;
            dcf_q   <= 1'b1;
          end
        end
        StRun: begin
          if (!bus.enable_In) begin
            state_q <= StIdle;
            presc_q <= '0;
            ms_q    <= '0;
            sec_q   <= '0;
            fs_q    <= 1'b0;
            dcf_q   <= 1'b0;
          end else begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
            sec_q   <= sec_d;
            fs_q    <= frame_wrap;
            dcf_q   <= dcf_d;
            if (frame_wrap) begin
              tad_q  <= bus.timeAndDate_In[43:7];
`ifdef DCF_PARITY_INJECT_EN
              perr_q <= bus.parityErr_In;
`else
              perr_q <= 1'b0;
`endif
            end
          end
        end
      endcase
    end
  end

  assign bus.dcfSignal_Out   = dcf_q;
  assign bus.frameStart_Out  = fs_q;
  assign bus.secondIndex_Out = sec_q;

endmodule

// File: tb/tb_dcf77_signal_gen.sv
// Bench for dcf77_signal_gen: two instances (1 and 3 clocks per ms) checked every cycle
// against an elapsed-time frame model, plus hand-computed pulse lengths and frame period.
module tb_dcf77_signal_gen;

  localparam int CA = 1;
  localparam int CB = 3;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic done_a = 1'b0;
  logic done_b = 1'b0;
  int   checks = 0;
  int   errors = 0;
  longint cyc = 0;

  dcf77_signal_gen_if bus_a ();
  dcf77_signal_gen_if bus_b ();

  dcf77_signal_gen #(.CLKS_PER_MS(CA)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  dcf77_signal_gen #(.CLKS_PER_MS(CB)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

`ifdef DCF_PARITY_INJECT_EN
  assign bus_a.parityErr_In = 1'b0;
  assign bus_b.parityErr_In = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [43:0] mkvec(input logic [7:0] yr, input logic [7:0] mon,
                                        input logic [7:0] day, input logic [2:0] wd,
                                        input logic [7:0] hr, input logic [7:0] mn,
                                        input logic [7:0] sc, input logic [1:0] tz);
    logic [43:0] v;
    v        = '0;
    v[6:0]   = sc[6:0];
    v[13:7]  = mn[6:0];
    v[19:14] = hr[5:0];
    v[25:20] = day[5:0];
    v[30:26] = mon[4:0];
    v[38:31] = yr;
    v[41:39] = wd;
    v[43:42] = tz;
    return v;
  endfunction

  // Frame as a 60-entry bit table built field by field from the DCF77 layout.
  function automatic logic [59:0] model_frame(input logic [43:0] v, input logic perr);
    logic [59:0] f;
    logic [6:0]  mn;
    logic [5:0]  hr, dy;
    logic [2:0]  wd;
    logic [4:0]  mo;
    logic [7:0]  yr;
    mn = v[13:7]; hr = v[19:14]; dy = v[25:20]; wd = v[41:39]; mo = v[30:26]; yr = v[38:31];
    f = '0;
    f[17] = v[43];
    f[18] = v[42];
    f[20] = 1'b1;
    for (int k = 0; k < 7; k++) f[21 + k] = mn[k];
    f[28] = (($countones(mn) % 2) == 1) ^ perr;
    for (int k = 0; k < 6; k++) f[29 + k] = hr[k];
    f[35] = (($countones(hr) % 2) == 1) ^ perr;
    for (int k = 0; k < 6; k++) f[36 + k] = dy[k];
    for (int k = 0; k < 3; k++) f[42 + k] = wd[k];
    for (int k = 0; k < 5; k++) f[45 + k] = mo[k];
    for (int k = 0; k < 8; k++) f[50 + k] = yr[k];
    f[58] = ((($countones(dy) + $countones(wd) + $countones(mo) + $countones(yr)) % 2) == 1)
            ^ perr;
    return f;
  endfunction

  typedef struct packed {
    logic        act;
    logic [31:0] el;   // cycles since the current frame started
    logic [59:0] frm;
  } mstate_t;

  function automatic mstate_t mstep(input mstate_t s, input logic en, input logic [43:0] v,
                                    input int frame_len);
    mstate_t n;
    n = s;
    if (!s.act) begin
      if (en) begin
        n.act = 1'b1;
        n.el  = 0;
        n.frm = model_frame(v, 1'b0);
      end
    end else if (!en) begin
      n.act = 1'b0;
      n.el  = 0;
    end else if (int'(s.el) == frame_len - 1) begin
      n.el  = 0;
      n.frm = model_frame(v, 1'b0);
    end else begin
      n.el = s.el + 1;
    end
    return n;
  endfunction

  // Expected {dcf, frameStart, secondIndex} from elapsed time alone.
  function automatic logic [7:0] mexp(input mstate_t s, input int c);
    int   sec, ms, lim;
    logic d;
    if (!s.act) return 8'h00;
    sec = int'(s.el) / (1000 * c);
    ms  = (int'(s.el) % (1000 * c)) / c;
    lim = s.frm[sec] ? 200 : 100;
    d   = (sec < 59) && (ms < lim);
    return {d, (s.el == 0), 6'(sec)};
  endfunction

  mstate_t ma, mb;

  always @(posedge clk or posedge rst_a)
    if (rst_a) ma <= '0;
    else ma <= mstep(ma, bus_a.enable_In, bus_a.timeAndDate_In, 60000 * CA);

  always @(posedge clk or posedge rst_b)
    if (rst_b) mb <= '0;
    else mb <= mstep(mb, bus_b.enable_In, bus_b.timeAndDate_In, 60000 * CB);

  always @(negedge clk) begin
    check("model_a", {bus_a.dcfSignal_Out, bus_a.frameStart_Out, bus_a.secondIndex_Out},
          mexp(ma, CA));
    check("model_b", {bus_b.dcfSignal_Out, bus_b.frameStart_Out, bus_b.secondIndex_Out},
          mexp(mb, CB));
  end

  // Pulse-length and frame-start monitors on instance A.
  int     plen [60];
  int     pcnt = 0;
  int     psec = 0;
  longint fs_t [$];

  always @(negedge clk) begin
    if (bus_a.dcfSignal_Out) begin
      pcnt <= pcnt + 1;
      psec <= int'(bus_a.secondIndex_Out);
    end else if (pcnt > 0) begin
      plen[psec] <= pcnt;
      pcnt       <= 0;
    end
    if (bus_a.frameStart_Out) fs_t.push_back(cyc);
  end

  // Instance A: full frame 23:59 Tue 2019-07-31 (tz=10), switched to 00:00 (tz=01) at second 30.
  initial begin
    logic [43:0] v1, v0;
    logic [59:0] f;
    int b1_sec [21] = '{0, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28,
                        29, 30, 31, 32, 33, 34, 35, 58};
    int b1_len [21] = '{100, 200, 100, 100, 200, 200, 100, 100, 200, 200, 100, 200, 100,
                        200, 200, 100, 100, 100, 200, 200, 100};
    int b2_sec [10] = '{17, 18, 21, 22, 23, 24, 25, 26, 27, 28};
    int b2_len [10] = '{100, 200, 100, 100, 100, 100, 100, 100, 100, 100};
    v1 = mkvec(8'h19, 8'h07, 8'h31, 3'd2, 8'h23, 8'h59, 8'h45, 2'b10);
    v0 = mkvec(8'h19, 8'h07, 8'h31, 3'd2, 8'h00, 8'h00, 8'h30, 2'b01);
    bus_a.enable_In      = 1'b0;
    bus_a.timeAndDate_In = '0;
    #1 rst_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;

    f = model_frame(v1, 1'b0);
    check("model_bits_21_35", f[35:21], 15'b1_100011_0_1011001);
    check("model_p3", f[58], 1'b0);
    check("model_tz_bits", f[20:17], 4'b1001);
    f = model_frame(v0, 1'b0);
    check("model_zero_time", f[35:21], 15'd0);

    @(negedge clk);
    check("a_idle_dcf", bus_a.dcfSignal_Out, 1'b0);
    bus_a.timeAndDate_In = v1;
    bus_a.enable_In      = 1'b1;
    @(negedge clk);
    check("a_start_strobe", {bus_a.frameStart_Out, bus_a.dcfSignal_Out}, 2'b11);
    repeat (30499) @(negedge clk);
    bus_a.timeAndDate_In = v0;
    repeat (30000) @(negedge clk);
    for (int i = 0; i < 21; i++)
      check($sformatf("f1_pulse_s%0d", b1_sec[i]), plen[b1_sec[i]], b1_len[i]);
    check("frame_start_count", fs_t.size(), 2);
    if (fs_t.size() >= 2) check("frame_period", fs_t[1] - fs_t[0], 60000);
    repeat (29000) @(negedge clk);
    for (int i = 0; i < 10; i++)
      check($sformatf("f2_pulse_s%0d", b2_sec[i]), plen[b2_sec[i]], b2_len[i]);
    done_a = 1'b1;
  end

  // Instance B: reset mid-pulse, then enable drop at second 12 ms 50 and restart.
  initial begin
    bus_b.enable_In      = 1'b0;
    bus_b.timeAndDate_In = mkvec(8'h19, 8'h07, 8'h31, 3'd2, 8'h23, 8'h59, 8'h45, 2'b01);
    #1 rst_b = 1'b1;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    bus_b.enable_In = 1'b1;
    repeat (30) @(negedge clk);
    check("b_pulse_before_reset", bus_b.dcfSignal_Out, 1'b1);
    #2 rst_b = 1'b1;
    bus_b.enable_In = 1'b0;
    #1;
    check("b_reset_dcf", bus_b.dcfSignal_Out, 1'b0);
    check("b_reset_fs", bus_b.frameStart_Out, 1'b0);
    check("b_reset_sec", bus_b.secondIndex_Out, 6'd0);
    @(negedge clk);
    rst_b = 1'b0;
    repeat (10) @(negedge clk);
    bus_b.enable_In = 1'b1;
    repeat (36151) @(negedge clk);
    check("b_sec12_index", bus_b.secondIndex_Out, 6'd12);
    check("b_sec12_pulse", bus_b.dcfSignal_Out, 1'b1);
    bus_b.enable_In = 1'b0;
    @(negedge clk);
    check("b_drop_dcf", bus_b.dcfSignal_Out, 1'b0);
    check("b_drop_sec", bus_b.secondIndex_Out, 6'd0);
    repeat (4) @(negedge clk);
    bus_b.enable_In = 1'b1;
    @(negedge clk);
    check("b_restart", {bus_b.frameStart_Out, bus_b.dcfSignal_Out, bus_b.secondIndex_Out},
          {2'b11, 6'd0});
    @(negedge clk);
    check("b_strobe_one_cycle", bus_b.frameStart_Out, 1'b0);
    repeat (6000) @(negedge clk);
    done_b = 1'b1;
  end

  initial begin
    fork
      wait (done_a && done_b);
      repeat (100000) @(posedge clk);
    join_any
    disable fork;
    check("stimulus_done", {done_a, done_b}, 2'b11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
